mem_arbiter: RTL and testbench



---
 rtl/memory_types_pkg.sv | 24 ++
 rtl/arb_tag_fifo.sv | 57 +++++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_types_pkg.sv
// Shared memory-port types: request packet, requester IDs and arbiter states.
package memory_types_pkg;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_pkt_t;

  typedef enum logic {
    REQ_IMEM = 1'b0,
    REQ_DMEM = 1'b1
  } mem_req_id_t;

  typedef enum logic {
    ARB,
    HOLD
  } arb_state_t;

  function automatic mem_req_id_t other_req(mem_req_id_t id);
    return (id == REQ_IMEM) ? REQ_DMEM : REQ_IMEM;
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order 1-bit tag FIFO recording which requester owns each outstanding request.
module arb_tag_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin imem/dmem arbiter onto one memory port; responses routed back by tag FIFO.
module mem_arbiter
  import memory_types_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     imem_req_vld,
  output logic     imem_req_rdy,
  input  mem_pkt_t imem_req,
  output logic     imem_rsp_vld,
  input  logic     imem_rsp_rdy,
  output mem_pkt_t imem_rsp,
  input  logic     dmem_req_vld,
  output logic     dmem_req_rdy,
  input  mem_pkt_t dmem_req,
  output logic     dmem_rsp_vld,
  input  logic     dmem_rsp_rdy,
  output mem_pkt_t dmem_rsp,
  output logic     mem_req_vld,
  input  logic     mem_req_rdy,
  output mem_pkt_t mem_req,
  input  logic     mem_rsp_vld,
  output logic     mem_rsp_rdy,
  input  mem_pkt_t mem_rsp,
  output logic     err_unexpected_rsp
);

  arb_state_t  state_q;
  mem_req_id_t prio_q, gnt_q, winner, head_id;
  logic        err_q, has_win, grant_ok, push, pop;
  logic        tag_full, tag_empty, tag_head;

  always_comb begin
    has_win = 1'b0;
    winner  = REQ_IMEM;
    if (state_q == HOLD) begin
      winner  = gnt_q;
      has_win = (gnt_q == REQ_IMEM) ? imem_req_vld : dmem_req_vld;
    end else if (imem_req_vld && dmem_req_vld) begin
      has_win = 1'b1;
      winner  = prio_q;
    end else if (imem_req_vld) begin
      has_win = 1'b1;
      winner  = REQ_IMEM;
    end else if (dmem_req_vld) begin
      has_win = 1'b1;
      winner  = REQ_DMEM;
    end
  end

  // Full blocks the grant on the registered count; a same-cycle pop does not help.
  assign grant_ok     = has_win && !tag_full && rst_n;
  assign mem_req_vld  = grant_ok;
  assign mem_req      = (winner == REQ_DMEM) ? dmem_req : imem_req;
  assign imem_req_rdy = grant_ok && (winner == REQ_IMEM) && mem_req_rdy;
  assign dmem_req_rdy = grant_ok && (winner == REQ_DMEM) && mem_req_rdy;
  assign push         = grant_ok && mem_req_rdy;

  assign head_id      = mem_req_id_t'(tag_head);
  assign imem_rsp_vld = mem_rsp_vld && !tag_empty && rst_n && (head_id == REQ_IMEM);
  assign dmem_rsp_vld = mem_rsp_vld && !tag_empty && rst_n && (head_id == REQ_DMEM);
  assign mem_rsp_rdy  = !tag_empty && rst_n &&
                        ((head_id == REQ_DMEM) ? dmem_rsp_rdy : imem_rsp_rdy);
  assign pop          = mem_rsp_vld && mem_rsp_rdy;
  assign imem_rsp     = mem_rsp;
  assign dmem_rsp     = mem_rsp;

  assign err_unexpected_rsp = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB;
      prio_q  <= REQ_IMEM;
      gnt_q   <= REQ_IMEM;
      err_q   <= 1'b0;
    end else begin
      if (mem_rsp_vld && tag_empty) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        ARB: begin
          if (push) begin
            prio_q <= other_req(winner);
          end else if (grant_ok) begin
            state_q <= HOLD;
            gnt_q   <= winner;
          end
        end
        HOLD: begin
          if (push) begin
            prio_q  <= other_req(winner);
            state_q <= ARB;
          end
        end
      endcase
    end
  end

  arb_tag_fifo #(
    .Depth(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (push),
    .data_i (winner == REQ_DMEM),
    .pop_i  (pop),
    .full_o (tag_full),
    .empty_o(tag_empty),
    .head_o (tag_head)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: streaming, contention, backpressure, full, HOL, reset.
module tb_mem_arbiter;
  import memory_types_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     imem_req_vld, imem_req_rdy, imem_rsp_vld, imem_rsp_rdy;
  logic     dmem_req_vld, dmem_req_rdy, dmem_rsp_vld, dmem_rsp_rdy;
  logic     mem_req_vld, mem_req_rdy, mem_rsp_vld, mem_rsp_rdy, err_unexpected_rsp;
  mem_pkt_t imem_req, imem_rsp, dmem_req, dmem_rsp, mem_req, mem_rsp;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_req_vld      (imem_req_vld),
    .imem_req_rdy      (imem_req_rdy),
    .imem_req          (imem_req),
    .imem_rsp_vld      (imem_rsp_vld),
    .imem_rsp_rdy      (imem_rsp_rdy),
    .imem_rsp          (imem_rsp),
    .dmem_req_vld      (dmem_req_vld),
    .dmem_req_rdy      (dmem_req_rdy),
    .dmem_req          (dmem_req),
    .dmem_rsp_vld      (dmem_rsp_vld),
    .dmem_rsp_rdy      (dmem_rsp_rdy),
    .dmem_rsp          (dmem_rsp),
    .mem_req_vld       (mem_req_vld),
    .mem_req_rdy       (mem_req_rdy),
    .mem_req           (mem_req),
    .mem_rsp_vld       (mem_rsp_vld),
    .mem_rsp_rdy       (mem_rsp_rdy),
    .mem_rsp           (mem_rsp),
    .err_unexpected_rsp(err_unexpected_rsp)
  );

  function automatic mem_pkt_t mk_pkt(logic [31:0] a);
    mem_pkt_t p;
    p.we   = 1'b0;
    p.addr = a;
    p.data = ~a;
    return p;
  endfunction

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    #2;
    check_val("rst_mem_req_vld", 64'(mem_req_vld), 64'd0);
    check_val("rst_imem_req_rdy", 64'(imem_req_rdy), 64'd0);
    check_val("rst_dmem_req_rdy", 64'(dmem_req_rdy), 64'd0);
    check_val("rst_mem_rsp_rdy", 64'(mem_rsp_rdy), 64'd0);
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic clear_inputs();
    imem_req_vld = 1'b0; imem_req = mk_pkt(32'h0); imem_rsp_rdy = 1'b1;
    dmem_req_vld = 1'b0; dmem_req = mk_pkt(32'h0); dmem_rsp_rdy = 1'b1;
    mem_req_rdy  = 1'b1; mem_rsp_vld = 1'b0; mem_rsp = mk_pkt(32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // imem streaming with 1-cycle memory latency
    do_reset();
    check_val("init_err", 64'(err_unexpected_rsp), 64'd0);
    imem_req_vld = 1'b1;
    imem_req     = mk_pkt(32'h0);
    #2;
    check_val("s0_vld", 64'(mem_req_vld), 64'd1);
    check_val("s0_addr", 64'(mem_req.addr), 64'h0);
    check_val("s0_rdy", 64'(imem_req_rdy), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (i < 3) imem_req = mk_pkt(32'(4 * i));
      else imem_req_vld = 1'b0;
      mem_rsp_vld = 1'b1;
      mem_rsp     = mk_pkt(32'h100 + 32'(4 * (i - 1)));
      #2;
      check_val("s_req_vld", 64'(mem_req_vld), (i < 3) ? 64'd1 : 64'd0);
      if (i < 3) check_val("s_req_addr", 64'(mem_req.addr), 64'(4 * i));
      check_val("s_imem_rsp_vld", 64'(imem_rsp_vld), 64'd1);
      check_val("s_dmem_rsp_vld", 64'(dmem_rsp_vld), 64'd0);
      check_val("s_mem_rsp_rdy", 64'(mem_rsp_rdy), 64'd1);
      check_val("s_imem_rsp_addr", 64'(imem_rsp.addr), 64'h100 + 64'(4 * (i - 1)));
    end
    cyc();
    mem_rsp_vld = 1'b0;
    #2;
    check_val("s_drain_vld", 64'(imem_rsp_vld), 64'd0);
    check_val("s_no_err", 64'(err_unexpected_rsp), 64'd0);

    // contention from reset, then full FIFO, HOL blocking, reset with traffic
    clear_inputs();
    imem_req_vld = 1'b1; imem_req = mk_pkt(32'h1000);
    dmem_req_vld = 1'b1; dmem_req = mk_pkt(32'h2000);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #2;
      check_val("c_addr", 64'(mem_req.addr), (i % 2 == 0) ? 64'h1000 : 64'h2000);
      check_val("c_imem_rdy", 64'(imem_req_rdy), (i % 2 == 0) ? 64'd1 : 64'd0);
      check_val("c_dmem_rdy", 64'(dmem_req_rdy), (i % 2 == 0) ? 64'd0 : 64'd1);
      cyc();
    end
    mem_rsp_vld = 1'b1;
    mem_rsp     = mk_pkt(32'hA0);
    #2;
    check_val("full_req_vld", 64'(mem_req_vld), 64'd0);
    check_val("full_imem_rdy", 64'(imem_req_rdy), 64'd0);
    check_val("full_dmem_rdy", 64'(dmem_req_rdy), 64'd0);
    check_val("full_pop_vld", 64'(imem_rsp_vld), 64'd1);
    check_val("full_pop_rdy", 64'(mem_rsp_rdy), 64'd1);
    cyc();
    mem_rsp_vld = 1'b0;
    #2;
    check_val("refill_vld", 64'(mem_req_vld), 64'd1);
    check_val("refill_addr", 64'(mem_req.addr), 64'h1000);
    check_val("refill_rdy", 64'(imem_req_rdy), 64'd1);
    cyc();
    imem_req_vld = 1'b0; dmem_req_vld = 1'b0;
    mem_rsp_vld  = 1'b1; dmem_rsp_rdy = 1'b0;
    #2;
    check_val("hol_dmem_vld", 64'(dmem_rsp_vld), 64'd1);
    check_val("hol_imem_vld", 64'(imem_rsp_vld), 64'd0);
    check_val("hol_rsp_rdy", 64'(mem_rsp_rdy), 64'd0);
    cyc();
    dmem_rsp_rdy = 1'b1;
    #2;
    check_val("hol_release_rdy", 64'(mem_rsp_rdy), 64'd1);
    check_val("hol_release_vld", 64'(dmem_rsp_vld), 64'd1);
    cyc();
    #2;
    check_val("hol_next_imem", 64'(imem_rsp_vld), 64'd1);
    check_val("hol_next_dmem", 64'(dmem_rsp_vld), 64'd0);
    cyc();
    rst_n = 1'b0;
    #2;
    check_val("rt_mem_rsp_rdy", 64'(mem_rsp_rdy), 64'd0);
    check_val("rt_dmem_rsp_vld", 64'(dmem_rsp_vld), 64'd0);
    check_val("rt_imem_rsp_vld", 64'(imem_rsp_vld), 64'd0);
    cyc();
    rst_n = 1'b1;
    #2;
    check_val("rt_after_rdy", 64'(mem_rsp_rdy), 64'd0);
    check_val("rt_after_dvld", 64'(dmem_rsp_vld), 64'd0);
    check_val("rt_after_ivld", 64'(imem_rsp_vld), 64'd0);
    check_val("rt_err_clear", 64'(err_unexpected_rsp), 64'd0);
    cyc();
    mem_rsp_vld = 1'b0;
    #2;
    check_val("rt_err_set", 64'(err_unexpected_rsp), 64'd1);
    cyc();
    #2;
    check_val("rt_err_sticky", 64'(err_unexpected_rsp), 64'd1);

    // downstream backpressure holds the dmem grant
    clear_inputs();
    do_reset();
    imem_req_vld = 1'b1; imem_req = mk_pkt(32'h3000);
    cyc();
    dmem_req_vld = 1'b1; dmem_req = mk_pkt(32'h4000);
    imem_req     = mk_pkt(32'h3004);
    mem_req_rdy  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check_val("bp_addr", 64'(mem_req.addr), 64'h4000);
      check_val("bp_vld", 64'(mem_req_vld), 64'd1);
      check_val("bp_imem_rdy", 64'(imem_req_rdy), 64'd0);
      check_val("bp_dmem_rdy", 64'(dmem_req_rdy), 64'd0);
      cyc();
    end
    mem_req_rdy = 1'b1;
    #2;
    check_val("bp_accept_addr", 64'(mem_req.addr), 64'h4000);
    check_val("bp_accept_dmem", 64'(dmem_req_rdy), 64'd1);
    check_val("bp_accept_imem", 64'(imem_req_rdy), 64'd0);
    cyc();
    dmem_req_vld = 1'b0;
    #2;
    check_val("bp_next_addr", 64'(mem_req.addr), 64'h3004);
    check_val("bp_next_imem", 64'(imem_req_rdy), 64'd1);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
